one_bit_alu: RTL and testbench

- Registered single-bit ALU slice performing AND, OR, XOR or full-add on two 1-bit operands under a 2-bit opcode.
- Carry-in/carry-out make slices cascadable into wider ALUs.
- Sits in the datapath as a leaf compute element.
- Result appears one clock after the operands are presented.

---
 rtl/alu_pkg.sv | 11 +
 rtl/one_bit_alu_if.sv | 26 ++
 rtl/one_bit_full_adder.sv | 13 +
 rtl/one_bit_alu.sv | 66 ++++++
 tb/tb_one_bit_alu.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings for the single-bit ALU slice.
package alu_pkg;

  typedef logic [1:0] alu_op_t;

  localparam alu_op_t OP_AND = 2'b00;
  localparam alu_op_t OP_OR  = 2'b01;
  localparam alu_op_t OP_XOR = 2'b10;
  localparam alu_op_t OP_ADD = 2'b11;

endpackage

// File: rtl/one_bit_alu_if.sv
// Operand/result bundle for one_bit_alu.
// Handshake: valid-only. A transfer occurs at every rising clk edge where
// in_valid=1, with no ready. out_valid marks the single cycle holding a fresh result.
interface one_bit_alu_if;
  import alu_pkg::*;

  logic    in_valid;
  logic    a;
  logic    b;
  logic    cin;
  alu_op_t sel;
  logic    out;
  logic    cout;
  logic    out_valid;

  modport master (
    output in_valid, a, b, cin, sel,
    input  out, cout, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin, sel,
    output out, cout, out_valid
  );

endinterface

// File: rtl/one_bit_full_adder.sv
// Combinational single-bit full adder used by the ALU ADD opcode.
module one_bit_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/one_bit_alu.sv
// Registered single-bit ALU slice: AND/OR/XOR/ADD with one-cycle latency.
// Carry-in/carry-out allow slices to be cascaded into wider datapaths.
module one_bit_alu
    import alu_pkg::*;
#(
    parameter logic RESET_OUT = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    one_bit_alu_if.slave  bus
);

    logic add_sum;
    logic add_cout;
    logic res_out;
    logic res_cout;
    logic out_q;
    logic cout_q;
    logic valid_q;

    one_bit_full_adder u_fa (
        .a    (bus.a),
        .b    (bus.b),
        .cin  (bus.cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // cin only reaches the result through the adder, so logic ops ignore it.
    always_comb begin
        res_out  = 1'b0;
        res_cout = 1'b0;
        case (bus.sel)
            OP_AND: res_out = bus.a & bus.b;
            OP_OR:  res_out = bus.a | bus.b;
            OP_XOR: res_out = bus.a ^ bus.b;
            OP_ADD: begin
                res_out  = add_sum;
                res_cout = add_cout;
            end
            default: begin
                res_out  = 1'b0;
                res_cout = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= RESET_OUT;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                out_q  <= res_out;
                cout_q <= res_cout;
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.cout      = cout_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_one_bit_alu.sv
// Directed bench for one_bit_alu: reset, logic ops, full ADD sweep, hold, mid-stream reset.
module tb_one_bit_alu;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  // Expected {out_valid, cout, out}, pushed at issue and popped one edge later.
  logic [2:0] exp_q[$];

  one_bit_alu_if bus ();

  one_bit_alu #(.RESET_OUT(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock/reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input alu_op_t s, input logic a,
                       input logic b, input logic c);
    bus.in_valid = v;
    bus.sel      = s;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
  endtask

  // Advance one active edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: {out_valid,cout,out} got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] observed();
    return {bus.out_valid, bus.cout, bus.out};
  endfunction

  // Hand-computed ADD results {cout,out} indexed by {a,b,cin}.
  logic [1:0] add_exp [8];

  initial begin
    add_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    n_tests = 0;
    n_fail  = 0;

    // Reset held two cycles with live operands presented.
    rst_n = 1'b0;
    drive(1'b1, OP_AND, 1'b1, 1'b1, 1'b0);
    step();
    check("reset_cycle1", observed(), 3'b000);
    step();
    check("reset_cycle2", observed(), 3'b000);

    // First result after release: ADD 1+1+0.
    rst_n = 1'b1;
    drive(1'b1, OP_ADD, 1'b1, 1'b1, 1'b0);
    step();
    check("first_after_reset", observed(), 3'b110);

    // Logic ops.
    drive(1'b1, OP_AND, 1'b1, 1'b0, 1'b0);
    step();
    check("and_1_0", observed(), 3'b100);
    drive(1'b1, OP_OR, 1'b1, 1'b0, 1'b0);
    step();
    check("or_1_0", observed(), 3'b101);
    drive(1'b1, OP_XOR, 1'b0, 1'b1, 1'b0);
    step();
    check("xor_0_1", observed(), 3'b101);
    drive(1'b1, OP_XOR, 1'b1, 1'b1, 1'b1);
    step();
    check("xor_1_1_cin", observed(), 3'b100);

    // ADD sweep back-to-back over all operand combinations.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [2:0] e;
      string tag;
      v = 3'(i);
      drive(1'b1, OP_ADD, v[2], v[1], v[0]);
      exp_q.push_back({1'b1, add_exp[i]});
      step();
      e = exp_q.pop_front();
      tag = $sformatf("add_%b", v);
      check(tag, observed(), e);
    end

    // cin must not leak into logic ops.
    drive(1'b1, OP_AND, 1'b1, 1'b1, 1'b1);
    step();
    check("cin_isolation_and", observed(), 3'b101);
    drive(1'b1, OP_OR, 1'b0, 1'b0, 1'b1);
    step();
    check("cin_isolation_or", observed(), 3'b100);

    // Hold: OR result stays while in_valid is low and inputs toggle.
    drive(1'b1, OP_OR, 1'b1, 1'b0, 1'b0);
    step();
    check("hold_issue", observed(), 3'b101);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, alu_op_t'(i), 1'(i), 1'(i + 1), 1'b1);
      step();
      check($sformatf("hold_idle%0d", i), observed(), 3'b001);
    end

    // Hold keeps a set carry as well.
    drive(1'b1, OP_ADD, 1'b1, 1'b1, 1'b1);
    step();
    check("carry_issue", observed(), 3'b111);
    drive(1'b0, OP_AND, 1'b0, 1'b0, 1'b0);
    step();
    check("carry_hold", observed(), 3'b011);

    // Reset mid-stream discards the live result.
    drive(1'b1, OP_ADD, 1'b1, 1'b1, 1'b0);
    step();
    check("midrst_issue", observed(), 3'b110);
    rst_n = 1'b0;
    drive(1'b1, OP_ADD, 1'b1, 1'b1, 1'b1);
    step();
    check("midrst_asserted", observed(), 3'b000);
    rst_n = 1'b1;
    drive(1'b0, OP_ADD, 1'b1, 1'b1, 1'b1);
    step();
    check("midrst_no_stale", observed(), 3'b000);
    drive(1'b1, OP_XOR, 1'b1, 1'b0, 1'b0);
    step();
    check("midrst_resume", observed(), 3'b101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
